// File: rtl/rgb2hsv_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2hsv_if
//  Brief    : Pixel-in / pixel-out handshake bundle for the RGB-to-HSV
//             converter. The master side is the pixel source and sink. The
//             slave side is the converter itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface rgb2hsv_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] tRGB;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] tHSV;
  logic        busy;

  modport master (
    output in_valid, tRGB, out_ready,
    input  in_ready, out_valid, tHSV, busy
  );

  modport slave (
    input  in_valid, tRGB, out_ready,
    output in_ready, out_valid, tHSV, busy
  );
endinterface
`default_nettype wire

// File: rtl/rgb2hsv.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2hsv
//  Brief    : Multi-cycle RGB888 -> packed HSV888 converter. One 16/8
//             restoring divider is shared: it first produces S, then H.
//             Hue is scaled so that each 60-degree sextant spans HUE_SEXTANT
//             codes.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb2hsv #(
  parameter int HUE_SEXTANT = 43,
  parameter int DIV_STEPS   = 16
) (
  input  logic     clk,
  input  logic     reset,
  rgb2hsv_if.slave bus
);

  localparam int               CNT_W     = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(DIV_STEPS - 1);
  localparam logic [7:0]       C_BASE_R  = 8'd0;
  localparam logic [7:0]       C_BASE_G  = 8'(2 * HUE_SEXTANT);
  localparam logic [7:0]       C_BASE_B  = 8'(4 * HUE_SEXTANT);
  localparam logic [15:0]      C_HUE_MUL = 16'(HUE_SEXTANT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_DIV_S = 3'd2,
    S_DIV_H = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [23:0]          rgb_q;
  logic [7:0]           v_q;
  logic [7:0]           delta_q;
  logic [7:0]           base_q;
  logic [7:0]           absnum_q;
  logic                 neg_q;
  logic [7:0]           s_q;
  logic [7:0]           div_q;     // divisor
  logic [DIV_STEPS-1:0] dq_q;      // dividend shifting out, quotient shifting in
  logic [7:0]           rem_q;     // partial remainder, always < divisor
  logic [CNT_W-1:0]     cnt_q;
  logic [23:0]          hsv_q;

  logic [7:0]  w_r, w_g, w_b;
  logic [7:0]  w_max, w_min, w_delta, w_base, w_p, w_m, w_abs;
  logic        w_neg;
  logic [15:0] w_div_s, w_div_h;
  logic [8:0]  w_rem_sh;
  logic        w_ge;
  logic [7:0]  w_rem_d;
  logic [DIV_STEPS-1:0] w_dq_d;
  logic        w_last;
  logic [7:0]  w_q8, w_hue;

  assign w_r = rgb_q[23:16];
  assign w_g = rgb_q[15:8];
  assign w_b = rgb_q[7:0];

  // Max-channel selection with R > G > B tie priority, plus hue numerator terms
  always_comb begin
    w_max  = w_b;
    w_base = C_BASE_B;
    w_p    = w_r;
    w_m    = w_g;
    if (w_r >= w_g && w_r >= w_b) begin
      w_max  = w_r;
      w_base = C_BASE_R;
      w_p    = w_g;
      w_m    = w_b;
    end else if (w_g >= w_b) begin
      w_max  = w_g;
      w_base = C_BASE_G;
      w_p    = w_b;
      w_m    = w_r;
    end
    w_min = w_r;
    if (w_g < w_min) w_min = w_g;
    if (w_b < w_min) w_min = w_b;
    w_delta = w_max - w_min;
    w_neg   = (w_p < w_m);
    w_abs   = w_neg ? (w_m - w_p) : (w_p - w_m);
    // 255*delta computed as 256*delta - delta
    w_div_s = {w_delta, 8'h00} - {8'h00, w_delta};
  end

  // One restoring-division step, plus the hue composition from its final quotient
  always_comb begin
    w_rem_sh = {rem_q, dq_q[DIV_STEPS-1]};
    w_ge     = (w_rem_sh >= {1'b0, div_q});
    w_rem_d  = w_ge ? 8'(w_rem_sh - {1'b0, div_q}) : w_rem_sh[7:0];
    w_dq_d   = {dq_q[DIV_STEPS-2:0], w_ge};
    w_last   = (cnt_q == C_LAST);
    // Legal operands keep the quotient within 8 bits
    w_q8     = w_dq_d[7:0];
    w_hue    = neg_q ? (base_q - w_q8) : (base_q + w_q8);
    w_div_h  = C_HUE_MUL * {8'h00, absnum_q};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_PREP;
      S_PREP:  state_d = (w_delta == 8'd0) ? S_DONE : S_DIV_S;
      S_DIV_S: if (w_last) state_d = S_DIV_H;
      S_DIV_H: if (w_last) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: pixel capture, operand prep, shared divider, result register
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q    <= '0;
      v_q      <= '0;
      delta_q  <= '0;
      base_q   <= '0;
      absnum_q <= '0;
      neg_q    <= 1'b0;
      s_q      <= '0;
      div_q    <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      hsv_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) rgb_q <= bus.tRGB;
        end
        S_PREP: begin
          v_q      <= w_max;
          delta_q  <= w_delta;
          base_q   <= w_base;
          absnum_q <= w_abs;
          neg_q    <= w_neg;
          div_q    <= w_max;
          dq_q     <= DIV_STEPS'(w_div_s);
          rem_q    <= '0;
          cnt_q    <= '0;
          // Gray/black bypass: the divider is never started with delta = 0
          if (w_delta == 8'd0) hsv_q <= {16'h0000, w_max};
        end
        S_DIV_S: begin
          dq_q  <= w_dq_d;
          rem_q <= w_rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (w_last) begin
            s_q   <= w_q8;
            div_q <= delta_q;
            dq_q  <= DIV_STEPS'(w_div_h);
            rem_q <= '0;
            cnt_q <= '0;
          end
        end
        S_DIV_H: begin
          dq_q  <= w_dq_d;
          rem_q <= w_rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (w_last) hsv_q <= {w_hue, s_q, v_q};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.tHSV      = hsv_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb2hsv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb2hsv
//  Brief    : Self-checking bench for rgb2hsv. Uses directed and random pixels
//             against a plain-arithmetic HSV reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb2hsv;

  localparam int HUE_SEXTANT = 43;
  localparam int DIV_STEPS   = 16;
  localparam int MAX_WAIT    = 200;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  rgb2hsv_if bus ();

  rgb2hsv #(
    .HUE_SEXTANT (HUE_SEXTANT),
    .DIV_STEPS   (DIV_STEPS)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference HSV, straight from the colour-space formulas in integer form
  function automatic logic [23:0] ref_hsv(input logic [23:0] rgb);
    int r, g, b, mx, mn, d, s, num, base, q, h;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    d  = mx - mn;
    if (d == 0) return {16'h0000, 8'(mx)};
    s = (255 * d) / mx;
    if (r == mx)      begin num = g - b; base = 0;               end
    else if (g == mx) begin num = b - r; base = 2 * HUE_SEXTANT; end
    else              begin num = r - g; base = 4 * HUE_SEXTANT; end
    q = (HUE_SEXTANT * ((num < 0) ? -num : num)) / d;
    h = (num >= 0) ? (base + q) : (base - q);
    h = ((h % 256) + 256) % 256;
    return {8'(h), 8'(s), 8'(mx)};
  endfunction

  function automatic bit is_gray(input logic [23:0] rgb);
    return (rgb[23:16] == rgb[15:8]) && (rgb[15:8] == rgb[7:0]);
  endfunction

  // Push one pixel, wait for the result, optionally hold out_ready low, then hand off.
  // Latency is counted in cycles from the accept edge (cycle 0) to the edge
  // at which the sink first sees out_valid.
  task automatic run_pixel(input logic [23:0] rgb, input int hold, input bit chk_lat);
    logic [23:0] exp;
    int  cyc;
    bit  seen;
    exp = ref_hsv(rgb);
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.tRGB     = rgb;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.tRGB     = 24'($urandom);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < MAX_WAIT && !seen) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("busy_running", 32'(bus.busy), 32'd1);
        check("in_ready_running", 32'(bus.in_ready), 32'd0);
      end
      if (bus.out_valid) begin
        seen = 1'b1;
        bus.in_valid = 1'b0;
      end else begin
        // Stray requests while busy must be ignored
        bus.in_valid = 1'($urandom);
        bus.tRGB     = 24'($urandom);
        @(posedge clk);
        cyc++;
      end
    end
    check("out_valid_timeout", 32'(seen), 32'd1);
    check("tHSV", 32'(bus.tHSV), 32'(exp));
    if (chk_lat)
      check("latency", 32'(cyc + 1), is_gray(rgb) ? 32'd2 : 32'(2 + 2 * DIV_STEPS));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.tRGB     = 24'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_tHSV", 32'(bus.tHSV), 32'(exp));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("handoff_out_valid", 32'(bus.out_valid), 32'd0);
    check("handoff_in_ready", 32'(bus.in_ready), 32'd1);
    check("handoff_busy", 32'(bus.busy), 32'd0);
    check("handoff_tHSV_hold", 32'(bus.tHSV), 32'(exp));
  endtask

  logic [23:0] rnd;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.tRGB      = 24'h0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_tHSV", 32'(bus.tHSV), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed pixels
    run_pixel(24'hFF0000, 0, 1'b1);
    run_pixel(24'h00FF00, 0, 1'b1);
    run_pixel(24'h0000FF, 0, 1'b1);
    run_pixel(24'h808080, 0, 1'b1);
    run_pixel(24'h000000, 0, 1'b1);
    run_pixel(24'hFF0080, 0, 1'b1);
    run_pixel(24'hC86432, 0, 1'b1);
    run_pixel(24'hFF0000, 10, 1'b1);

    // Reset during DIV_S cycle 5: accept edge, PREP edge, then five divider edges
    @(negedge clk);
    bus.tRGB     = 24'hC86432;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_pixel(24'hC86432, 0, 1'b1);

    // Random pixels, some forced gray, with random backpressure
    for (int n = 0; n < 40; n++) begin
      rnd = 24'($urandom);
      if ($urandom_range(0, 7) == 0) rnd = {rnd[7:0], rnd[7:0], rnd[7:0]};
      run_pixel(rnd, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb2hsv.md
Name: rgb2hsv

Overview:
- Converts one 24-bit RGB pixel to packed 8-bit HSV, ready for the hue-sextant HSV-to-RGB stage downstream (hue scaled so that each 60° sextant spans HUE_SEXTANT codes).
- Sits between the pixel fetch/colour-reduction path and HSV processing.
- Multi-cycle and area-lean: one shared 16/8 restoring divider computes S, then H.
- valid/ready handshake on both sides.

Parameters:
HUE_SEXTANT, 43, hue codes per 60° sextant; G-max base = 2*HUE_SEXTANT, B-max base = 4*HUE_SEXTANT.
DIV_STEPS, 16, iterations per division (one quotient bit per cycle; dividend width).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  tRGB valid.
in_ready  out  1  block can accept a pixel; high only in IDLE.
tRGB  in  24  {R[23:16], G[15:8], B[7:0]}.
out_valid  out  1  tHSV valid; held until accepted.
out_ready  in  1  downstream accepts tHSV.
tHSV  out  24  {H[23:16], S[15:8], V[7:0]}.
busy  out  1  high in every state except IDLE.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, tHSV=0, busy=0, state=IDLE.
- Reset asserted mid-operation aborts the conversion. The pixel is discarded, out_valid drops at the next edge, and the FSM returns to IDLE.
- Arithmetic:
  - max/min over R,G,B; delta = max - min; V = max.
  - S = 0 if delta = 0, else floor(255*delta/max). Dividend is 16 bits, max 65025.
  - H = 0 if delta = 0. Otherwise, max-channel tie priority is R, then G, then B:
    - R max: num = G - B, base = 0.
    - G max: num = B - R, base = 2*HUE_SEXTANT.
    - B max: num = R - G, base = 4*HUE_SEXTANT.
  - q = floor(HUE_SEXTANT*|num|/delta). Truncation is on the magnitude; q ≤ HUE_SEXTANT.
  - H = (base + q) mod 256 if num ≥ 0, else (base - q) mod 256 (wraps, e.g. 256-21=235).
- FSM states: IDLE, PREP, DIV_S, DIV_H, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready, capture tRGB and go to PREP.
  - PREP (1 cycle): compute max, min, delta, base, |num|, sign. If delta = 0, set H=S=0 and go directly to DONE. Otherwise load divider with 255*delta / max and go to DIV_S.
  - DIV_S (DIV_STEPS cycles): latch S[7:0] from the quotient, reload the divider with HUE_SEXTANT*|num| / delta, go to DIV_H.
  - DIV_H (DIV_STEPS cycles): form H and go to DONE.
  - DONE: out_valid=1 with tHSV stable. On out_ready, go to IDLE and clear out_valid at the same edge.
- in_ready is low in DONE; no same-cycle accept on handoff.
- Latency, with the accept edge as cycle 0:
  - delta ≠ 0: out_valid high in cycle 2+2*DIV_STEPS (34 by default).
  - delta = 0: out_valid high in cycle 2.
- Throughput: the next accept is possible 1 cycle after output handoff.
- tHSV changes only on the edge entering DONE. It holds its last value after handoff until the next result.
- Divider: quotient never exceeds 8 bits for legal inputs; upper quotient bits are ignored. The divisor is never 0, because the delta = 0 bypass guarantees it.
- in_valid while busy is ignored; no capture.

Test Plan:
- tRGB=0xFF0000 -> tHSV=0x00FFFF, out_valid in cycle 34.
- tRGB=0x00FF00 -> 0x56FFFF; tRGB=0x0000FF -> 0xACFFFF (sextant 2 and 4 boundaries for the downstream stage).
- tRGB=0x808080 and tRGB=0x000000 (gray/black, delta=0) -> 0x000080 and 0x000000, out_valid in cycle 2.
- Hue wrap and fractions:
  - tRGB=0xFF0080 -> 0xEBFFFF (H=256-21).
  - tRGB=0xC86432 -> 0x0EBFC8 (H=14, S=191, V=200).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> tHSV stable, in_ready=0, busy=1. Pulse in_valid with a new pixel during this window -> not captured.
- Reset in DIV_S cycle 5 -> next cycle out_valid=0, in_ready=1, busy=0. A fresh 0xC86432 afterwards -> 0x0EBFC8 with full latency.
